// File: rtl/line_buffer_3x3.sv
// Raster-order RGB line buffer feeding a 3x3 window extractor.
// Keeps the two previous rows and a column-shift window; one output stage with win_ready backpressure.
module line_buffer_3x3 #(
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int KERNEL_SIZE = 3
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [23:0] out_data_1,
  output logic [23:0] out_data_2,
  output logic [23:0] out_data_3,
  output logic [23:0] out_data_4,
  output logic [23:0] out_data_5,
  output logic [23:0] out_data_6,
  output logic [23:0] out_data_7,
  output logic [23:0] out_data_8,
  output logic [23:0] out_data_9,
  output logic        buf_valid,
  output logic        row2_cond,
  output logic        frame_end,
  input  logic        win_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [23:0]   lb1 [WIDTH];
  logic [23:0]   lb2 [WIDTH];
  logic [23:0]   win [KERNEL_SIZE][KERNEL_SIZE];
  logic [23:0]   new_col [KERNEL_SIZE];
  logic          accept;
  logic          last_col;
  logic          last_row;

  assign pix_ready = !buf_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign last_col  = (col == CW'(WIDTH - 1));
  assign last_row  = (row == RW'(HEIGHT - 1));

  // Incoming window column: oldest row at the top, the live pixel at the bottom.
  always_comb begin
    new_col[0] = lb2[col];
    new_col[1] = lb1[col];
    new_col[2] = pix_in;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < WIDTH; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
    end else if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
          win[i][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
          win[i][k] <= win[i][k+1];
        end
        win[i][KERNEL_SIZE-1] <= new_col[i];
      end
    end
  end

  // Border and row-wrap windows are still emitted; row2_cond tells downstream to drop them.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      buf_valid <= 1'b0;
      row2_cond <= 1'b0;
      frame_end <= 1'b0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      row2_cond <= (row >= RW'(2)) && (col >= CW'(2));
      frame_end <= last_row && last_col;
    end else if (win_ready) begin
      buf_valid <= 1'b0;
    end
  end

  assign out_data_1 = win[0][0];
  assign out_data_2 = win[0][1];
  assign out_data_3 = win[0][2];
  assign out_data_4 = win[1][0];
  assign out_data_5 = win[1][1];
  assign out_data_6 = win[1][2];
  assign out_data_7 = win[2][0];
  assign out_data_8 = win[2][1];
  assign out_data_9 = win[2][2];

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Self-checking bench for line_buffer_3x3: history-based window scoreboard plus a table of hand-derived windows.
// Covers continuous, stalled, bubbly, back-to-back and reset-interrupted frames on a 4x4 image.
module tb_line_buffer_3x3;

  localparam int W = 4;
  localparam int H = 4;

  typedef logic [8:0][23:0] win_t;
  typedef struct packed {
    win_t d;
    logic cond;
    logic fend;
  } exp_t;
  typedef struct packed {
    logic [7:0]  n;
    logic [23:0] d1;
    logic [23:0] d5;
    logic [23:0] d9;
    logic        cond;
    logic        fend;
  } vec_t;

  logic        clk;
  logic        rstb;
  logic [23:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] out_data_1, out_data_2, out_data_3, out_data_4, out_data_5;
  logic [23:0] out_data_6, out_data_7, out_data_8, out_data_9;
  logic        buf_valid;
  logic        row2_cond;
  logic        frame_end;
  logic        win_ready;

  line_buffer_3x3 #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(3)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_data_3 (out_data_3),
    .out_data_4 (out_data_4),
    .out_data_5 (out_data_5),
    .out_data_6 (out_data_6),
    .out_data_7 (out_data_7),
    .out_data_8 (out_data_8),
    .out_data_9 (out_data_9),
    .buf_valid  (buf_valid),
    .row2_cond  (row2_cond),
    .frame_end  (frame_end),
    .win_ready  (win_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  exp_t        sb[$];
  logic [23:0] hist [0:255];
  int          hcount;
  int          mr, mc;
  logic        exp_valid;
  logic [7:0]  tag;
  win_t        log_win [0:63];
  logic        log_cond [0:63];
  logic        log_fend [0:63];
  int          log_n;
  int          cond_cnt, fend_cnt;
  vec_t        tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] pix_of(input int r, input int c);
    return {8'(r), 8'(c), tag};
  endfunction

  // Window for the n-th accepted pixel of the raster stream: element (ro,co) back is n - ro*W - co.
  function automatic exp_t model_window(input int n);
    exp_t e;
    int   idx;
    for (int k = 0; k < 9; k++) begin
      idx = n - (2 - k / 3) * W - (2 - k % 3);
      e.d[k] = (idx < 0) ? 24'h0 : hist[idx];
    end
    e.cond = (mr >= 2 && mc >= 2);
    e.fend = (mr == H - 1 && mc == W - 1);
    return e;
  endfunction

  task automatic model_reset();
    sb.delete();
    hcount    = 0;
    mr        = 0;
    mc        = 0;
    exp_valid = 1'b0;
  endtask

  task automatic step(input logic pv, input logic wr, input bit alt, output logic acc);
    win_t act;
    exp_t e;
    logic cons;
    @(negedge clk);
    pix_valid = pv;
    win_ready = wr;
    pix_in    = pv ? pix_of(mr, mc) : 24'h0;
    #1;
    act = {out_data_9, out_data_8, out_data_7, out_data_6, out_data_5,
           out_data_4, out_data_3, out_data_2, out_data_1};
    check("pix_ready", pix_ready, !exp_valid || wr);
    check("buf_valid", buf_valid, exp_valid);
    if (exp_valid && sb.size() > 0) begin
      for (int k = 0; k < 9; k++) check($sformatf("out_data_%0d", k + 1), act[k], sb[0].d[k]);
      check("row2_cond", row2_cond, sb[0].cond);
      check("frame_end", frame_end, sb[0].fend);
    end
    cons = exp_valid && wr;
    acc  = pv && (!exp_valid || wr);
    if (cons && sb.size() > 0) begin
      e = sb.pop_front();
      if (row2_cond) cond_cnt++;
      if (frame_end) fend_cnt++;
      if (log_n < 64) begin
        log_win[log_n]  = act;
        log_cond[log_n] = row2_cond;
        log_fend[log_n] = frame_end;
      end
      log_n++;
    end
    if (acc) begin
      if (hcount < 256) hist[hcount] = pix_of(mr, mc);
      sb.push_back(model_window(hcount));
      hcount++;
      if (mc == W - 1) begin
        mc = 0;
        if (mr == H - 1) begin
          mr = 0;
          if (alt) tag = ~tag;
        end else begin
          mr++;
        end
      end else begin
        mc++;
      end
      exp_valid = 1'b1;
    end else if (cons) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int npix, input int vpct, input int stall_at, input bit alt);
    int   sent;
    int   cyc;
    logic pv, wr, acc;
    sent     = 0;
    cyc      = 0;
    log_n    = 0;
    cond_cnt = 0;
    fend_cnt = 0;
    while ((sent < npix || exp_valid) && cyc < 2000) begin
      pv = (sent < npix) && ($urandom_range(99) < vpct);
      wr = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      step(pv, wr, alt, acc);
      if (acc) sent++;
      cyc++;
    end
    if (cyc >= 2000) begin
      total_cnt++;
      $display("[TB] FAIL timeout: got %0d pixels sent expected %0d", sent, npix);
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic checkOutput();
    int n;
    for (int i = 0; i < 6; i++) begin
      n = int'(tbl[i].n);
      check($sformatf("tbl_n%0d_d1", n), log_win[n][0], tbl[i].d1);
      check($sformatf("tbl_n%0d_d5", n), log_win[n][4], tbl[i].d5);
      check($sformatf("tbl_n%0d_d9", n), log_win[n][8], tbl[i].d9);
      check($sformatf("tbl_n%0d_cond", n), log_cond[n], tbl[i].cond);
      check($sformatf("tbl_n%0d_fend", n), log_fend[n], tbl[i].fend);
    end
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_buf_valid"}, buf_valid, 1'b0);
    check({tagname, "_row2_cond"}, row2_cond, 1'b0);
    check({tagname, "_frame_end"}, frame_end, 1'b0);
    check({tagname, "_out1"}, out_data_1, 24'h0);
    check({tagname, "_out5"}, out_data_5, 24'h0);
    check({tagname, "_out9"}, out_data_9, 24'h0);
    check({tagname, "_pix_ready"}, pix_ready, 1'b1);
  endtask

  initial begin
    logic acc;
    // {n = r*W + c, out_data_1, out_data_5, out_data_9, row2_cond, frame_end} for a fresh frame
    tbl[0] = '{8'd0,  24'h000000, 24'h000000, 24'h00005A, 1'b0, 1'b0};
    tbl[1] = '{8'd4,  24'h000000, 24'h000000, 24'h01005A, 1'b0, 1'b0};
    tbl[2] = '{8'd8,  24'h000000, 24'h00035A, 24'h02005A, 1'b0, 1'b0};
    tbl[3] = '{8'd10, 24'h00005A, 24'h01015A, 24'h02025A, 1'b1, 1'b0};
    tbl[4] = '{8'd14, 24'h01005A, 24'h02015A, 24'h03025A, 1'b1, 1'b0};
    tbl[5] = '{8'd15, 24'h01015A, 24'h02025A, 24'h03035A, 1'b1, 1'b1};

    tag       = 8'h5A;
    rstb      = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 24'h0;
    win_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rstb = 1'b1;

    $display("[TB] continuous frame");
    applyStimulus(16, 100, -1, 1'b0);
    check("cont_windows", log_n, 16);
    check("cont_row2_count", cond_cnt, 4);
    check("cont_frame_end_count", fend_cnt, 1);
    checkOutput();

    $display("[TB] backpressure");
    applyStimulus(16, 100, 5, 1'b0);
    check("bp_windows", log_n, 16);
    check("bp_row2_count", cond_cnt, 4);
    check("bp_frame_end_count", fend_cnt, 1);

    $display("[TB] input bubbles");
    applyStimulus(16, 50, -1, 1'b0);
    check("bub_windows", log_n, 16);
    check("bub_row2_count", cond_cnt, 4);
    check("bub_frame_end_count", fend_cnt, 1);

    $display("[TB] back-to-back frames");
    applyStimulus(32, 100, -1, 1'b1);
    check("b2b_windows", log_n, 32);
    check("b2b_row2_count", cond_cnt, 8);
    check("b2b_frame_end_count", fend_cnt, 2);
    check("b2b_f2_out1", log_win[26][0], 24'h0000A5);
    check("b2b_f2_out5", log_win[26][4], 24'h0101A5);
    check("b2b_f2_out9", log_win[26][8], 24'h0202A5);
    check("b2b_f2_cond", log_cond[26], 1'b1);
    tag = 8'h5A;

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, acc);
    @(posedge clk);
    #2;
    pix_valid = 1'b0;
    check("pre_reset_buf_valid", buf_valid, 1'b1);
    rstb = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
    applyStimulus(16, 100, -1, 1'b0);
    check("rst_windows", log_n, 16);
    check("rst_row2_count", cond_cnt, 4);
    check("rst_frame_end_count", fend_cnt, 1);
    checkOutput();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
